// File: rtl/core_stdio_pkg.sv
// rtl/core_stdio_pkg.sv - shared types for the stdio byte/word bridge
package core_stdio_pkg;
  typedef logic [15:0] word_t;
  typedef logic [7:0]  byte_t;
  typedef enum logic {SEQ_HI = 1'b0, SEQ_LO = 1'b1} seq_e;
endpackage

// File: rtl/core_stdio_bridge_if.sv
// rtl/core_stdio_bridge_if.sv - host link and core stdio handshake bundle
interface core_stdio_bridge_if #(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
);
  import core_stdio_pkg::*;

  logic                       host_rx_val_i;
  byte_t                      host_rx_data_i;
  logic                       host_rx_rdy_o;
  logic                       core_in_val_o;
  word_t                      core_in_data_o;
  logic                       core_in_rdy_i;
  logic                       core_out_val_i;
  word_t                      core_out_data_i;
  logic                       core_out_rdy_o;
  logic                       host_tx_val_o;
  byte_t                      host_tx_data_o;
  logic                       host_tx_rdy_i;
  logic [$clog2(IN_DEPTH):0]  in_count_o;
  logic [$clog2(OUT_DEPTH):0] out_count_o;

  modport master (
    input  host_rx_val_i, host_rx_data_i, core_in_rdy_i,
    input  core_out_val_i, core_out_data_i, host_tx_rdy_i,
    output host_rx_rdy_o, core_in_val_o, core_in_data_o, core_out_rdy_o,
    output host_tx_val_o, host_tx_data_o, in_count_o, out_count_o
  );

  modport slave (
    output host_rx_val_i, host_rx_data_i, core_in_rdy_i,
    output core_out_val_i, core_out_data_i, host_tx_rdy_i,
    input  host_rx_rdy_o, core_in_val_o, core_in_data_o, core_out_rdy_o,
    input  host_tx_val_o, host_tx_data_o, in_count_o, out_count_o
  );
endinterface

// File: rtl/stdio_fifo.sv
// rtl/stdio_fifo.sv - first-word-fall-through word FIFO with sync flush
module stdio_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + ONE;
      end
      if (pop_ok) rptr <= rptr + ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/core_stdio_bridge.sv
// rtl/core_stdio_bridge.sv - packs host bytes into stdin words, serialises stdout words to bytes
module core_stdio_bridge
  import core_stdio_pkg::*;
#(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                flush_i,
  core_stdio_bridge_if.master bus
);
  seq_e  rx_q, rx_d, tx_q, tx_d;
  byte_t hi_q, hi_d;
  word_t in_head, out_head;
  logic  in_full, in_empty, out_full, out_empty;
  logic  rx_rdy, rx_acc, in_push, in_pop;
  logic  tx_acc, out_push, out_pop;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rx_q <= SEQ_HI;
      tx_q <= SEQ_HI;
      hi_q <= '0;
    end else if (flush_i) begin
      rx_q <= SEQ_HI;
      tx_q <= SEQ_HI;
      hi_q <= '0;
    end else begin
      rx_q <= rx_d;
      tx_q <= tx_d;
      hi_q <= hi_d;
    end
  end

  // A high byte is always taken; a low byte waits until the word has a slot.
  always_comb begin
    rx_d    = rx_q;
    hi_d    = hi_q;
    in_push = 1'b0;
    rx_rdy  = (rx_q == SEQ_HI) || !in_full;
    rx_acc  = bus.host_rx_val_i && rx_rdy;
    if (rx_acc) begin
      if (rx_q == SEQ_HI) begin
        hi_d = bus.host_rx_data_i;
        rx_d = SEQ_LO;
      end else begin
        in_push = 1'b1;
        rx_d    = SEQ_HI;
      end
    end
  end

  always_comb begin
    tx_d    = tx_q;
    out_pop = 1'b0;
    tx_acc  = !out_empty && bus.host_tx_rdy_i;
    if (tx_acc) begin
      if (tx_q == SEQ_HI) begin
        tx_d = SEQ_LO;
      end else begin
        out_pop = 1'b1;
        tx_d    = SEQ_HI;
      end
    end
  end

  assign in_pop   = bus.core_in_rdy_i && !in_empty;
  assign out_push = bus.core_out_val_i && !out_full;

  assign bus.host_rx_rdy_o  = rx_rdy;
  assign bus.core_in_val_o  = !in_empty;
  assign bus.core_in_data_o = in_head;
  assign bus.core_out_rdy_o = !out_full;
  assign bus.host_tx_val_o  = !out_empty;
  assign bus.host_tx_data_o = (tx_q == SEQ_HI) ? out_head[15:8] : out_head[7:0];

  stdio_fifo #(.DEPTH(IN_DEPTH), .WIDTH(16)) u_in_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .flush   (flush_i),
    .push    (in_push),
    .wdata   ({hi_q, bus.host_rx_data_i}),
    .pop     (in_pop),
    .rdata   (in_head),
    .full    (in_full),
    .empty   (in_empty),
    .count   (bus.in_count_o)
  );

  stdio_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(16)) u_out_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .flush   (flush_i),
    .push    (out_push),
    .wdata   (bus.core_out_data_i),
    .pop     (out_pop),
    .rdata   (out_head),
    .full    (out_full),
    .empty   (out_empty),
    .count   (bus.out_count_o)
  );
endmodule

// File: tb/tb_core_stdio_bridge.sv
// tb/tb_core_stdio_bridge.sv - directed self-checking bench for core_stdio_bridge
module tb_core_stdio_bridge;
  import core_stdio_pkg::*;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  core_stdio_bridge_if #(.IN_DEPTH(16), .OUT_DEPTH(16)) bif ();

  core_stdio_bridge #(.IN_DEPTH(16), .OUT_DEPTH(16)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .flush_i (flush),
    .bus     (bif.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input byte_t b);
    int n = 0;
    bif.host_rx_val_i  = 1'b1;
    bif.host_rx_data_i = b;
    while (!bif.host_rx_rdy_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rx_rdy_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bif.host_rx_val_i = 1'b0;
  endtask

  task automatic core_push(input word_t w);
    check("core_out_rdy", 32'(bif.core_out_rdy_o), 32'd1);
    bif.core_out_val_i  = 1'b1;
    bif.core_out_data_i = w;
    @(posedge clk); #1;
    bif.core_out_val_i = 1'b0;
  endtask

  task automatic core_pop();
    bif.core_in_rdy_i = 1'b1;
    @(posedge clk); #1;
    bif.core_in_rdy_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_rdy"}, 32'(bif.host_rx_rdy_o), 32'd1);
    check({tag, "_out_rdy"}, 32'(bif.core_out_rdy_o), 32'd1);
    check({tag, "_in_val"}, 32'(bif.core_in_val_o), 32'd0);
    check({tag, "_in_data"}, 32'(bif.core_in_data_o), 32'd0);
    check({tag, "_tx_val"}, 32'(bif.host_tx_val_o), 32'd0);
    check({tag, "_tx_data"}, 32'(bif.host_tx_data_o), 32'd0);
    check({tag, "_in_count"}, 32'(bif.in_count_o), 32'd0);
    check({tag, "_out_count"}, 32'(bif.out_count_o), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w;
    bif.host_rx_val_i   = 1'b0;
    bif.host_rx_data_i  = '0;
    bif.core_in_rdy_i   = 1'b0;
    bif.core_out_val_i  = 1'b0;
    bif.core_out_data_i = '0;
    bif.host_tx_rdy_i   = 1'b0;

    // Reset state
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Two bytes pack into one big-endian word
    rx_byte(8'h12);
    check("pack_hi_in_val", 32'(bif.core_in_val_o), 32'd0);
    rx_byte(8'h34);
    check("pack_in_val", 32'(bif.core_in_val_o), 32'd1);
    check("pack_in_data", 32'(bif.core_in_data_o), 32'h1234);
    check("pack_in_count", 32'(bif.in_count_o), 32'd1);
    core_pop();
    check("pop_in_count", 32'(bif.in_count_o), 32'd0);
    check("pop_in_val", 32'(bif.core_in_val_o), 32'd0);

    // Core word serialised high byte first
    core_push(16'hABCD);
    check("tx_val", 32'(bif.host_tx_val_o), 32'd1);
    check("tx_hi", 32'(bif.host_tx_data_o), 32'hAB);
    check("tx_out_count1", 32'(bif.out_count_o), 32'd1);
    bif.host_tx_rdy_i = 1'b1;
    @(posedge clk); #1;
    check("tx_lo", 32'(bif.host_tx_data_o), 32'hCD);
    check("tx_out_count_lo", 32'(bif.out_count_o), 32'd1);
    @(posedge clk); #1;
    bif.host_tx_rdy_i = 1'b0;
    check("tx_out_count0", 32'(bif.out_count_o), 32'd0);
    check("tx_val0", 32'(bif.host_tx_val_o), 32'd0);

    // Fill stdin, then a low byte must wait for space
    for (int k = 0; k < 16; k++) begin
      rx_byte(8'(k));
      rx_byte(8'(k + 128));
    end
    check("full_count", 32'(bif.in_count_o), 32'd16);
    check("full_rdy_hi", 32'(bif.host_rx_rdy_o), 32'd1);
    rx_byte(8'h55);
    check("full_rdy_lo", 32'(bif.host_rx_rdy_o), 32'd0);
    bif.host_rx_val_i  = 1'b1;
    bif.host_rx_data_i = 8'h66;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("full_hold_rdy", 32'(bif.host_rx_rdy_o), 32'd0);
    check("full_hold_count", 32'(bif.in_count_o), 32'd16);
    check("full_head", 32'(bif.core_in_data_o), 32'h0080);
    core_pop();
    check("full_pop_count", 32'(bif.in_count_o), 32'd15);
    check("full_pop_rdy", 32'(bif.host_rx_rdy_o), 32'd1);
    @(posedge clk); #1;
    bif.host_rx_val_i = 1'b0;
    check("full_refill_count", 32'(bif.in_count_o), 32'd16);
    for (int k = 1; k < 16; k++) begin
      w = {8'(k), 8'(k + 128)};
      check("drain_data", 32'(bif.core_in_data_o), 32'(w));
      core_pop();
    end
    check("drain_last", 32'(bif.core_in_data_o), 32'h5566);
    core_pop();
    check("drain_empty", 32'(bif.in_count_o), 32'd0);

    // Simultaneous push and pop at count 3, across pointer wrap
    for (int j = 0; j < 3; j++) begin
      w = 16'h1000 + 16'(j);
      rx_byte(w[15:8]);
      rx_byte(w[7:0]);
    end
    check("sim_count_start", 32'(bif.in_count_o), 32'd3);
    for (int j = 0; j < 40; j++) begin
      w = 16'h1000 + 16'(j + 3);
      rx_byte(w[15:8]);
      check("sim_head", 32'(bif.core_in_data_o), 32'h1000 + 32'(j));
      bif.host_rx_val_i  = 1'b1;
      bif.host_rx_data_i = w[7:0];
      bif.core_in_rdy_i  = 1'b1;
      @(posedge clk); #1;
      bif.host_rx_val_i = 1'b0;
      bif.core_in_rdy_i = 1'b0;
      check("sim_count", 32'(bif.in_count_o), 32'd3);
    end
    for (int j = 40; j < 43; j++) begin
      check("sim_tail", 32'(bif.core_in_data_o), 32'h1000 + 32'(j));
      core_pop();
    end
    check("sim_empty", 32'(bif.in_count_o), 32'd0);

    // Host stalls the low byte
    core_push(16'hBEEF);
    bif.host_tx_rdy_i = 1'b1;
    @(posedge clk); #1;
    bif.host_tx_rdy_i = 1'b0;
    repeat (5) begin
      check("stall_val", 32'(bif.host_tx_val_o), 32'd1);
      check("stall_data", 32'(bif.host_tx_data_o), 32'hEF);
      check("stall_count", 32'(bif.out_count_o), 32'd1);
      @(posedge clk); #1;
    end
    bif.host_tx_rdy_i = 1'b1;
    @(posedge clk); #1;
    bif.host_tx_rdy_i = 1'b0;
    check("stall_release", 32'(bif.out_count_o), 32'd0);

    // Flush with rx in LO and both FIFOs occupied; flush overrides transfers
    core_push(16'h1111);
    rx_byte(8'h21);
    rx_byte(8'h22);
    rx_byte(8'h23);
    check("pre_flush_in", 32'(bif.in_count_o), 32'd1);
    check("pre_flush_out", 32'(bif.out_count_o), 32'd1);
    flush = 1'b1;
    bif.host_rx_val_i   = 1'b1;
    bif.host_rx_data_i  = 8'h24;
    bif.core_out_val_i  = 1'b1;
    bif.core_out_data_i = 16'h2222;
    @(posedge clk); #1;
    flush = 1'b0;
    bif.host_rx_val_i  = 1'b0;
    bif.core_out_val_i = 1'b0;
    check("flush_in_count", 32'(bif.in_count_o), 32'd0);
    check("flush_out_count", 32'(bif.out_count_o), 32'd0);
    check("flush_tx_val", 32'(bif.host_tx_val_o), 32'd0);
    check("flush_in_val", 32'(bif.core_in_val_o), 32'd0);
    rx_byte(8'h31);
    rx_byte(8'h32);
    check("flush_rx_hi", 32'(bif.core_in_data_o), 32'h3132);
    core_pop();

    // Async reset between clock edges, mid-transfer
    core_push(16'h4444);
    rx_byte(8'h61);
    rx_byte(8'h62);
    rx_byte(8'h51);
    check("pre_rst_in", 32'(bif.in_count_o), 32'd1);
    bif.host_tx_rdy_i  = 1'b1;
    bif.host_rx_val_i  = 1'b1;
    bif.host_rx_data_i = 8'h52;
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bif.host_tx_rdy_i = 1'b0;
    bif.host_rx_val_i = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    rx_byte(8'h71);
    rx_byte(8'h72);
    check("rst_rx_hi", 32'(bif.core_in_data_o), 32'h7172);
    check("rst_in_count", 32'(bif.in_count_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_stdio_bridge.md
Name: core_stdio_bridge

Overview:
- Byte-stream bridge between the host link (UART/JTAG byte FIFO) and the core's stdin/stdout word interface.
- Sits directly upstream of the core's stdin port and directly downstream of its stdout port. Its core-facing pins connect to the stdio modports.
- Inbound path: packs host bytes, big-endian, into 16-bit words and buffers them in a FIFO for the core's LSU to read.
- Outbound path: buffers core words in a FIFO and serialises each one to the host as two bytes, high byte first.

Parameters:
- IN_DEPTH, 16, stdin word FIFO depth; power of 2, ≥2.
- OUT_DEPTH, 16, stdout word FIFO depth; power of 2, ≥2.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  reset; asynchronous, active-low (single clock domain, async active-low reset)
- flush_i  in  1  synchronous clear of both FIFOs and both byte sequencers
- host_rx_val_i  in  1  host byte valid
- host_rx_data_i  in  8  host byte
- host_rx_rdy_o  out  1  bridge accepts host byte
- core_in_val_o  out  1  stdin word available (stdin_intf val)
- core_in_data_o  out  16  stdin word (FWFT)
- core_in_rdy_i  in  1  core consumes word
- core_out_val_i  in  1  core stdout word valid
- core_out_data_i  in  16  stdout word
- core_out_rdy_o  out  1  bridge accepts stdout word
- host_tx_val_o  out  1  byte to host valid
- host_tx_data_o  out  8  byte to host
- host_tx_rdy_i  in  1  host accepts byte
- in_count_o  out  $clog2(IN_DEPTH)+1  stdin FIFO occupancy
- out_count_o  out  $clog2(OUT_DEPTH)+1  stdout FIFO occupancy

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where val && rdy. Data is sampled on that edge.
- Reset values (arst_ni low):
  - host_rx_rdy_o=1, core_out_rdy_o=1.
  - core_in_val_o=0, core_in_data_o=0.
  - host_tx_val_o=0, host_tx_data_o=0.
  - both counts 0.
  - both sequencers in state HI.
- flush_i: same effect as reset, one cycle later. It overrides all transfers in that cycle.
- Rx packer FSM (states HI, LO):
  - HI: an accepted byte is latched into hi_q; go to LO.
  - LO: an accepted byte forms word {hi_q, byte}, which is pushed to the stdin FIFO; go to HI.
  - host_rx_rdy_o = (state==HI) || ~in_full. A high byte is always accepted; a low byte waits for FIFO space.
- Stdin FIFO:
  - First-word-fall-through: core_in_data_o = mem[rptr]; core_in_val_o = ~empty.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full = MSBs differ and the low bits are equal.
  - A push and a pop in the same cycle are both honoured and the count is unchanged.
  - No push is possible when full, because rdy gates it.
  - When empty, core_in_data_o holds the last mem[rptr] value, which is don't-care. A bench must not check it.
- Stdout FIFO:
  - core_out_rdy_o = ~out_full. Push and pop rules match the stdin FIFO.
- Tx serialiser FSM (states HI, LO):
  - host_tx_val_o = ~out_empty.
  - host_tx_data_o = head[15:8] in HI, head[7:0] in LO.
  - Accept in HI: go to LO.
  - Accept in LO: pop the FIFO and go to HI.
  - The host may stall indefinitely; data stays stable while val && ~rdy.
- Latency:
  - host byte → core word: the core sees the word on the cycle after the low byte is accepted.
  - core word → first tx byte: one cycle.
- Counts:
  - Registered; each equals pushes minus pops since reset/flush.
  - Range 0..DEPTH. They reach DEPTH exactly when full.

Decomposition:
- Package core_stdio_pkg holds:
  - typedef word_t (logic [15:0]) and byte_t (logic [7:0]);
  - enum seq_e {SEQ_HI, SEQ_LO}.
- Sub-module stdio_fifo:
  - parameterised by DEPTH and WIDTH;
  - FWFT, with push/pop/full/empty/count and sync flush;
  - instantiated twice.
- The two FSMs live in the top module.

Test Plan:
- Reset then bytes 0x12,0x34 → core_in_val_o=1, core_in_data_o=0x1234 one cycle after 0x34 accepted; in_count_o=1.
- Core pushes 0xABCD, host_tx_rdy_i=1 → tx bytes 0xAB then 0xCD on consecutive cycles; out_count_o 1→0 on the 0xCD accept.
- Fill stdin with 16 words (IN_DEPTH=16), core_in_rdy_i=0:
  - a further byte 0x55 is accepted into HI;
  - the next byte is not accepted while host_rx_rdy_o=0 (rdy holds 0);
  - one core pop completes word 0x55xx; rdy returns to 1.
- Simultaneous stdin push and pop at count 3 → count stays 3; data order preserved across pointer wrap after 40 words.
- Host stalls tx with head 0xBEEF in LO (0xEF held 5 cycles) → val and data stable; no pop until accept.
- Assert flush_i with rx in LO and both FIFOs non-empty → next cycle counts 0, rx in HI, host_tx_val_o=0.
- Assert arst_ni low mid-transfer → outputs go to reset values immediately, before the next clock edge.
